reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter BYPASS, default 1, meaning that write data is forwarded to the read ports in the cycle it is written (0 means no forwarding).
REQ-002 The block SHALL have port CLK  input  1  single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port RF_ADR1  input  5  read address, port 1.
REQ-005 The block SHALL have port RF_ADR2  input  5  read address, port 2.
REQ-006 The block SHALL have port RF_RS1  output  32  read data, port 1.
REQ-007 The block SHALL have port RF_RS2  output  32  read data, port 2.
REQ-008 The block SHALL have port RF_WA  input  5  write address.
REQ-009 The block SHALL have port RF_WD  input  32  write data, driven by the 4:1 write-back source mux.
REQ-010 The block SHALL have port RF_EN  input  1  write enable.
REQ-011 The block SHALL have port LD_ISSUE  input  1  a load whose destination is LD_RD issues this cycle.
REQ-012 The block SHALL have port LD_RD  input  5  destination of the issuing load.
REQ-013 The block SHALL have port RF_STALL  output  1  a read operand is pending a load result.
REQ-014 The block SHALL have port RF_BUSY  output  32  scoreboard bit vector, where bit i is set while register xi is pending.

Function
REQ-015 Storage SHALL be 32 x 32-bit registers x0..x31.
REQ-016 x0 SHALL read as 32'h0 at all times, and writes to x0 and load issues to x0 SHALL be ignored.
REQ-017 A write SHALL occur at the CLK rising edge when RF_EN=1 and RF_WA!=0, storing RF_WD into x[RF_WA], visible on the read ports from the next cycle.
REQ-018 Reads SHALL be combinational: RF_RS1 = x[RF_ADR1] and RF_RS2 = x[RF_ADR2], with zero-cycle latency.
REQ-019 When BYPASS=1, RF_EN=1, RF_WA!=0 and RF_ADR1==RF_WA, RF_RS1 SHALL equal RF_WD in that same cycle; the same rule SHALL apply to port 2.
REQ-020 When BYPASS=0, read ports SHALL return the pre-write stored value during the write cycle.
REQ-021 At the rising edge, LD_ISSUE=1 with LD_RD!=0 SHALL set BUSY[LD_RD].
REQ-022 At the rising edge, RF_EN=1 with RF_WA!=0 SHALL clear BUSY[RF_WA].
REQ-023 When a set and a clear hit the same index on the same edge, the set SHALL win: BUSY ends at 1, because the new load is younger.
REQ-024 A set and a clear at different indices SHALL both take effect on the same edge.
REQ-025 BUSY[0] SHALL be constantly 0.
REQ-026 RF_STALL SHALL be combinational: (BUSY[RF_ADR1] & ~clr1) | (BUSY[RF_ADR2] & ~clr2).
REQ-027 clrN SHALL be 1 only when BYPASS=1, RF_EN=1 and RF_WA==RF_ADRN, meaning the pending value is being forwarded this cycle; when BYPASS=0, clrN SHALL be 0.
REQ-028 Addresses equal to 0 SHALL never cause a stall.
REQ-029 RF_STALL SHALL NOT depend on LD_ISSUE in the same cycle; a same-cycle issue SHALL affect only the next cycle.
REQ-030 Multiple outstanding loads to distinct registers SHALL be tracked independently, with no limit beyond 31.
REQ-031 A write to a non-busy register SHALL leave the scoreboard unchanged apart from the clear rule, which has no effect on a bit that is already 0.

Reset
REQ-032 When RST=1, all x0..x31 SHALL be cleared to 0 and all BUSY bits cleared immediately, without waiting for CLK.
REQ-033 While RST=1, RF_RS1=RF_RS2=0 (after any bypass term, with bypass suppressed during reset), RF_STALL=0 and RF_BUSY=0.
REQ-034 Write and issue events SHALL be ignored on any edge at which RST=1.
REQ-035 Reset asserted mid-operation SHALL drop all pending loads, and a post-reset write to a formerly busy register SHALL have no scoreboard effect.
REQ-036 After RST deasserts, the first CLK edge SHALL operate normally.

Verification
REQ-037 Write/read: write x5=32'h12345678 with EN=1; on the next cycle ADR1=5 -> RS1=32'h12345678, and ADR2=0 -> RS2=0.
REQ-038 x0 protection: WA=0, WD=32'hdeadbeef, EN=1; on the next cycle ADR1=0 -> RS1=0, and LD_ISSUE with LD_RD=0 -> BUSY=0.
REQ-039 Bypass: with BYPASS=1, WA=7, WD=32'hA5A5A5A5, EN=1 and ADR2=7 in the same cycle -> RS2=32'hA5A5A5A5; with BYPASS=0 -> the old x7 value.
REQ-040 Scoreboard: LD_ISSUE with LD_RD=3 -> next cycle BUSY=32'h8, and ADR1=3 -> STALL=1; then WA=3, EN=1 -> STALL=0 that cycle (BYPASS=1) and BUSY=0 on the next cycle.
REQ-041 Same-index collision: BUSY[9]=1; LD_ISSUE with LD_RD=9 and EN=1 with WA=9 on the same edge -> BUSY[9] remains 1 and x9 holds the written value.
REQ-042 Async reset: with x4=32'hFF and BUSY[4]=1, pulse RST between clock edges -> RS(4)=0 and BUSY=0 before the next edge, and STALL=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// 32 x 32-bit integer register file (x0 hard-wired to zero) with two
// combinational read ports, one write port and a load scoreboard.
//
// The scoreboard keeps one "pending" bit per register. An issuing load marks
// its destination busy. The write-back that returns the value clears the bit
// again. RF_STALL tells the pipeline that an operand it is reading is still
// waiting for a load result.
//
// Parameters
//   BYPASS    1: write data is forwarded to the read ports in the write cycle
//             0: read ports return the stored (pre-write) value
//
// Ports
//   CLK       clock, all state updates on the rising edge
//   RST       asynchronous, active-high reset (clears registers and scoreboard)
//   RF_ADR1   read address, port 1
//   RF_ADR2   read address, port 2
//   RF_RS1    read data, port 1
//   RF_RS2    read data, port 2
//   RF_WA     write address
//   RF_WD     write data (from the write-back source mux)
//   RF_EN     write enable
//   LD_ISSUE  a load targeting LD_RD issues this cycle
//   LD_RD     destination register of the issuing load
//   RF_STALL  a read operand is pending a load result
//   RF_BUSY   scoreboard vector, bit i set while xi is pending
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  RF_ADR1,
    input  logic [4:0]  RF_ADR2,
    output logic [31:0] RF_RS1,
    output logic [31:0] RF_RS2,
    input  logic [4:0]  RF_WA,
    input  logic [31:0] RF_WD,
    input  logic        RF_EN,
    input  logic        LD_ISSUE,
    input  logic [4:0]  LD_RD,
    output logic        RF_STALL,
    output logic [31:0] RF_BUSY
);

    logic [31:0][31:0] regs_q, regs_d;
    logic [31:0]       busy_q, busy_d;

    logic wr_en;
    logic ld_en;
    logic fwd1, fwd2;
    logic clr1, clr2;

    // Writes and load issues targeting x0 are dropped here, so neither the
    // storage nor the scoreboard can ever hold anything for x0.
    assign wr_en = RF_EN && (RF_WA != 5'd0);
    assign ld_en = LD_ISSUE && (LD_RD != 5'd0);

    // Next-state for storage and scoreboard. The clear is applied before the
    // set so that a load issuing to the register being written back keeps it
    // busy: the new load is younger than the value being returned.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[RF_WA] = RF_WD;
            busy_d[RF_WA] = 1'b0;
        end
        if (ld_en) begin
            busy_d[LD_RD] = 1'b1;
        end
        regs_d[0] = 32'h0;
        busy_d[0] = 1'b0;
    end

    // Reset clears everything immediately, independent of the clock, and
    // any write or issue presented on an edge during reset is lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Forwarding only applies to a real write (non-zero address) and is
    // suppressed during reset so the read ports show zero.
    assign fwd1 = BYPASS && wr_en && (RF_WA == RF_ADR1) && !RST;
    assign fwd2 = BYPASS && wr_en && (RF_WA == RF_ADR2) && !RST;

    // A pending operand that is being forwarded this very cycle no longer
    // needs to stall. Without forwarding the reader must wait one more cycle.
    assign clr1 = BYPASS && RF_EN && (RF_WA == RF_ADR1);
    assign clr2 = BYPASS && RF_EN && (RF_WA == RF_ADR2);

    // Combinational read ports and stall. busy_q[0] is never set, so address
    // zero can never stall. Stall looks only at registered busy bits, so a
    // load issuing this cycle affects only the next cycle.
    always_comb begin
        RF_RS1   = 32'h0;
        RF_RS2   = 32'h0;
        RF_STALL = 1'b0;
        if (!RST) begin
            RF_RS1   = fwd1 ? RF_WD : regs_q[RF_ADR1];
            RF_RS2   = fwd2 ? RF_WD : regs_q[RF_ADR2];
            RF_STALL = (busy_q[RF_ADR1] && !clr1) || (busy_q[RF_ADR2] && !clr2);
        end
    end

    assign RF_BUSY = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed bench for reg_file_sb. Two instances share every input: one
// built with forwarding (BYPASS=1) and one without (BYPASS=0). Each stimulus
// step pushes the hand-computed outputs of both instances for that cycle
// into a queue. A monitor pops and compares them mid-cycle.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    typedef struct {
        string       name;
        logic [31:0] rs1_b;
        logic [31:0] rs1_n;
        logic [31:0] rs2_b;
        logic [31:0] rs2_n;
        logic        stall_b;
        logic        stall_n;
        logic [31:0] busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  adr1, adr2, wa, ld_rd;
    logic [31:0] wd;
    logic        en, ld_issue;

    logic [31:0] rs1_b, rs2_b, busy_b;
    logic [31:0] rs1_n, rs2_n, busy_n;
    logic        stall_b, stall_n;

    exp_t scoreboard[$];
    int   total = 0;
    int   bad   = 0;

    reg_file_sb #(.BYPASS(1'b1)) dut_byp (
        .CLK(clk), .RST(rst),
        .RF_ADR1(adr1), .RF_ADR2(adr2),
        .RF_RS1(rs1_b), .RF_RS2(rs2_b),
        .RF_WA(wa), .RF_WD(wd), .RF_EN(en),
        .LD_ISSUE(ld_issue), .LD_RD(ld_rd),
        .RF_STALL(stall_b), .RF_BUSY(busy_b)
    );

    reg_file_sb #(.BYPASS(1'b0)) dut_nob (
        .CLK(clk), .RST(rst),
        .RF_ADR1(adr1), .RF_ADR2(adr2),
        .RF_RS1(rs1_n), .RF_RS2(rs2_n),
        .RF_WA(wa), .RF_WD(wd), .RF_EN(en),
        .LD_ISSUE(ld_issue), .LD_RD(ld_rd),
        .RF_STALL(stall_n), .RF_BUSY(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it if it differs.
    task automatic checkOutput(input string step, input string field,
                               input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%h want=%h", step, field, act, want);
        end
    endtask

    function automatic exp_t mkExp(input string name,
                                   input logic [31:0] r1b, input logic [31:0] r1n,
                                   input logic [31:0] r2b, input logic [31:0] r2n,
                                   input logic sb, input logic sn,
                                   input logic [31:0] busy);
        exp_t e;
        e.name = name; e.rs1_b = r1b; e.rs1_n = r1n; e.rs2_b = r2b; e.rs2_n = r2n;
        e.stall_b = sb; e.stall_n = sn; e.busy = busy;
        return e;
    endfunction

    // Drive one cycle of inputs just after the rising edge. With pulse set,
    // reset is raised and dropped again well before the next edge.
    task automatic applyStimulus(input logic r, input bit pulse,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 input logic e, input logic [4:0] w, input logic [31:0] d,
                                 input logic ld, input logic [4:0] rd, input exp_t ex);
        @(posedge clk);
        #1;
        adr1 = a1; adr2 = a2; en = e; wa = w; wd = d; ld_issue = ld; ld_rd = rd;
        if (pulse) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
        end else begin
            rst = r;
        end
        scoreboard.push_back(ex);
    endtask

    // Monitor: compare every queued expectation in the middle of its cycle.
    always @(negedge clk) begin
        while (scoreboard.size() > 0) begin
            exp_t ex;
            ex = scoreboard.pop_front();
            checkOutput(ex.name, "rs1_byp",   rs1_b,          ex.rs1_b);
            checkOutput(ex.name, "rs1_nob",   rs1_n,          ex.rs1_n);
            checkOutput(ex.name, "rs2_byp",   rs2_b,          ex.rs2_b);
            checkOutput(ex.name, "rs2_nob",   rs2_n,          ex.rs2_n);
            checkOutput(ex.name, "stall_byp", {31'h0, stall_b}, {31'h0, ex.stall_b});
            checkOutput(ex.name, "stall_nob", {31'h0, stall_n}, {31'h0, ex.stall_n});
            checkOutput(ex.name, "busy_byp",  busy_b,         ex.busy);
            checkOutput(ex.name, "busy_nob",  busy_n,         ex.busy);
        end
    end

    initial begin
        int waited;
        rst = 1'b1; adr1 = '0; adr2 = '0; wa = '0; wd = '0; en = 1'b0;
        ld_issue = 1'b0; ld_rd = '0;

        // Held in reset: outputs zero even with a matching write presented.
        applyStimulus(1, 0, 3, 5, 1, 3, 32'h0000ffff, 0, 0,
                      mkExp("reset", 0, 0, 0, 0, 0, 0, 0));
        // Write x5, forwarded only by the bypass instance.
        applyStimulus(0, 0, 5, 0, 1, 5, 32'h12345678, 0, 0,
                      mkExp("wr_x5", 32'h12345678, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 5, 3, 0, 0, 0, 0, 0,
                      mkExp("rd_x5", 32'h12345678, 32'h12345678, 0, 0, 0, 0, 0));
        // x0 ignores writes and load issues.
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hdeadbeef, 1, 0,
                      mkExp("wr_x0", 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,
                      mkExp("rd_x0", 0, 0, 0, 0, 0, 0, 0));
        // Load to x3: no stall in its own issue cycle.
        applyStimulus(0, 0, 3, 0, 0, 0, 0, 1, 3,
                      mkExp("ld3_issue", 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0,
                      mkExp("ld3_busy", 0, 0, 0, 0, 1, 1, 32'h8));
        applyStimulus(0, 0, 3, 0, 1, 3, 32'h00000333, 0, 0,
                      mkExp("ld3_fwd", 32'h333, 0, 0, 0, 0, 1, 32'h8));
        applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0,
                      mkExp("ld3_clr", 32'h333, 32'h333, 0, 0, 0, 0, 0));
        // Bypass on port 2.
        applyStimulus(0, 0, 0, 7, 1, 7, 32'h11111111, 0, 0,
                      mkExp("wr_x7", 0, 0, 32'h11111111, 0, 0, 0, 0));
        applyStimulus(0, 0, 5, 7, 1, 7, 32'ha5a5a5a5, 0, 0,
                      mkExp("bypass7", 32'h12345678, 32'h12345678,
                            32'ha5a5a5a5, 32'h11111111, 0, 0, 0));
        // Two outstanding loads, then a same-index set/clear collision on x9.
        applyStimulus(0, 0, 7, 9, 0, 0, 0, 1, 9,
                      mkExp("ld9_issue", 32'ha5a5a5a5, 32'ha5a5a5a5, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 9, 12, 0, 0, 0, 1, 12,
                      mkExp("ld12_issue", 0, 0, 0, 0, 1, 1, 32'h200));
        applyStimulus(0, 0, 9, 12, 1, 9, 32'h99990009, 1, 9,
                      mkExp("collide9", 32'h99990009, 0, 0, 0, 1, 1, 32'h1200));
        applyStimulus(0, 0, 9, 0, 0, 0, 0, 0, 0,
                      mkExp("after_collide", 32'h99990009, 32'h99990009, 0, 0, 1, 1, 32'h1200));
        // Clear x12 and set x4 on one edge.
        applyStimulus(0, 0, 12, 4, 1, 12, 32'h0000000c, 1, 4,
                      mkExp("set_clr_diff", 32'hc, 0, 0, 0, 0, 1, 32'h1200));
        // x4 = FF while staying busy (collision again).
        applyStimulus(0, 0, 4, 9, 1, 4, 32'h000000ff, 1, 4,
                      mkExp("x4_collide", 32'hff, 0, 32'h99990009, 32'h99990009, 1, 1, 32'h210));
        applyStimulus(0, 0, 4, 9, 0, 0, 0, 0, 0,
                      mkExp("pre_rst", 32'hff, 32'hff, 32'h99990009, 32'h99990009, 1, 1, 32'h210));
        // Reset pulse between edges wipes storage and scoreboard.
        applyStimulus(0, 1, 4, 9, 0, 0, 0, 0, 0,
                      mkExp("async_rst", 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 4, 9, 1, 4, 32'h00000055, 0, 0,
                      mkExp("post_rst_wr", 32'h55, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 4, 5, 0, 0, 0, 0, 0,
                      mkExp("post_rst_rd", 32'h55, 32'h55, 0, 0, 0, 0, 0));
        // Write and issue presented on an edge during reset are ignored.
        applyStimulus(1, 0, 4, 0, 1, 8, 32'h00000077, 1, 6,
                      mkExp("rst_held", 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 8, 6, 0, 0, 0, 0, 0,
                      mkExp("rst_release", 0, 0, 0, 0, 0, 0, 0));

        waited = 0;
        while (scoreboard.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (scoreboard.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain left=%0d want=0", scoreboard.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
